// File: rtl/fifo_main_gen_pkg.sv
// Shared definitions for the fifo_main_gen main-queue buffer.
// Contents: default geometry, the pause FSM state type and a helper that
// returns the width of occupancy-sized values (count and thresholds).
package fifo_main_gen_pkg;

    localparam int DEF_DATA_W = 6;
    localparam int DEF_ADDR_W = 2;

    // RUN: upstream may send; PAUSED: backpressure asserted.
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } pause_st_e;

    // Occupancy spans 0..2**addr_w inclusive, so it needs one extra bit.
    function automatic int occ_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_main_gen_ram_dp.sv
// Storage array for fifo_main_gen: DEPTH x DATA_W, one write port, one read port.
// Ports: clk, wr_en/wr_addr/wr_data (synchronous write),
//        rd_addr/rd_data (combinational read; the top level registers it).
// Contents are never reset; the pointers define what is valid.
module fifo_main_gen_ram_dp #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    // Write port: store the word on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_main_gen.sv
// fifo_main_gen: parametrised synchronous FIFO for the main queue, between the
// packet source and the VC demux.
// Ports: clk, reset_L (async active-low), push/data_in, pop, err_clr,
//        af_thr/ae_thr (occupancy thresholds, may change live),
//        data_out/data_valid (registered read data plus 1-cycle strobe),
//        full, empty, almost_full, almost_empty, pause (hysteretic
//        backpressure), error (sticky overflow/underflow), count (0..DEPTH).
// All status outputs are registered from the next-state count so they always
// agree with count in the same cycle.
module fifo_main_gen
    import fifo_main_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W:0]   af_thr,
    input  logic [ADDR_W:0]   ae_thr,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              pause,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    localparam int CW    = occ_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d, rd_data_s;
    logic              data_valid_q, data_valid_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic              error_q, error_d;
    pause_st_e         pst_q, pst_d;
    logic              pop_ok_s, push_ok_s;

    // A pop frees a slot in the same cycle, so a push on full is legal alongside it.
    assign pop_ok_s  = pop & ~empty_q;
    assign push_ok_s = push & (~full_q | pop_ok_s);

    fifo_main_gen_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_ok_s),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

    // Next-state for pointers, occupancy, read data and status flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = pop_ok_s;
        error_d      = error_q;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = rd_data_s;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            data_out_d = data_out_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
        af_d    = (count_d >= af_thr);
        ae_d    = (count_d <= ae_thr) && (count_d != CW'(0));

        // Set beats clear when an overflow/underflow coincides with err_clr.
        if ((push & full_q & ~pop_ok_s) | (pop & empty_q)) begin
            error_d = 1'b1;
        end else if (err_clr) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // Pause FSM next state: hysteresis between af_thr and ae_thr, set wins.
    always_comb begin
        pst_d = pst_q;
        if (count_d >= af_thr) begin
            pst_d = ST_PAUSED;
        end else if (count_d <= ae_thr) begin
            pst_d = ST_RUN;
        end else begin
            case (pst_q)
                ST_RUN:    pst_d = ST_RUN;
                ST_PAUSED: pst_d = ST_PAUSED;
                default:   pst_d = ST_RUN;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            af_q         <= 1'b0;
            ae_q         <= 1'b0;
            error_q      <= 1'b0;
            pst_q        <= ST_RUN;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            af_q         <= af_d;
            ae_q         <= ae_d;
            error_q      <= error_d;
            pst_q        <= pst_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign pause        = (pst_q == ST_PAUSED);
    assign error        = error_q;
    assign count        = count_q;

endmodule
